// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: two-client byte arbiter/sequencer for the TMS4464 SIMM DRAM controller.
// Clients p0/p1 present req/write/addr/wdata, get a gnt pulse when latched and a done pulse with rd_data.
// mem_* drive the controller's addr/write/ena/DQ and take back rd_data/busy/ack. err is a sticky timeout flag.
// DRAM_ARB_RR_EN selects round-robin between simultaneous requesters; undefined gives fixed priority to p0.
module dram_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [23:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [23:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [7:0]  rd_data,
  output logic        err,
  output logic [23:0] mem_addr,
  output logic        mem_write,
  output logic        mem_ena,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_busy,
  input  logic        mem_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic owner, sel, grant, abort, finish;
`ifdef DRAM_ARB_RR_EN
  logic last;
  assign sel = p0_req && p1_req ? ~last : p1_req;
`else
  assign sel = ~p0_req;
`endif
  // ack is only trusted together with busy; busy alone is a refresh, so keep waiting
  always_comb begin
    grant = state == IDLE && (p0_req || p1_req) && !mem_busy;
    abort = state != IDLE && cnt == '0;
    finish = state == WAIT_DONE && !mem_busy && !abort;
    state_n = grant ? ISSUE : abort || finish ? IDLE : state == ISSUE && mem_ack && mem_busy ? WAIT_DONE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      {p0_gnt, p1_gnt, p0_done, p1_done, mem_ena, mem_write, err, owner} <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rd_data <= '0;
      cnt <= '0;
    end else begin
      p0_gnt <= grant && !sel;
      p1_gnt <= grant && sel;
      p0_done <= (abort || finish) && !owner;
      p1_done <= (abort || finish) && owner;
      mem_ena <= state_n == ISSUE;
      cnt <= grant ? CW'(TIMEOUT) : state != IDLE ? cnt - 1'b1 : cnt;
      if (grant) begin
        owner <= sel;
        mem_addr <= sel ? p1_addr : p0_addr;
        mem_write <= sel ? p1_write : p0_write;
        mem_wdata <= sel ? p1_wdata : p0_wdata;
      end
      if (abort || finish) rd_data <= abort ? 8'hFF : mem_rd_data;
      if (abort) err <= 1'b1;
    end
  end
`ifdef DRAM_ARB_RR_EN
  always_ff @(posedge clk) last <= rst ? 1'b1 : grant ? sel : last;
`endif
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: scoreboard bench for dram_port_arbiter with a behavioural DRAM controller model.
module tb_dram_port_arbiter;
  logic clk = 0, rst = 1;
  logic p0_req = 0, p0_write = 0, p1_req = 0, p1_write = 0;
  logic [23:0] p0_addr = 0, p1_addr = 0;
  logic [7:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p1_gnt, p0_done, p1_done, err, mem_write, mem_ena;
  logic [7:0] rd_data, mem_wdata;
  logic [23:0] mem_addr;
  logic [7:0] mem_rd_data = 0;
  logic mem_busy = 0, mem_ack = 0;
  int m_cnt = 0, acc_len = 3;
  bit m_refr = 0, refresh_mode = 0, noack = 0;
  int errors = 0, checks = 0;
  int ena_cyc, viol, stable_bad, other_bad, ena_bad;
  typedef struct {bit done; bit port; logic [23:0] addr; bit wr; logic [7:0] data; bit err;} ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  dram_port_arbiter #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rd_data(rd_data), .err(err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_ena(mem_ena), .mem_wdata(mem_wdata),
    .mem_rd_data(mem_rd_data), .mem_busy(mem_busy), .mem_ack(mem_ack)
  );

  // controller model: no reset; optional 10-cycle refresh before the access, or never responds
  always @(posedge clk) begin
    mem_ack <= 0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        if (m_refr) begin
          m_refr <= 0;
          mem_ack <= 1;
          m_cnt <= acc_len;
        end else mem_busy <= 0;
      end
    end else if (mem_ena && !noack) begin
      mem_busy <= 1;
      if (refresh_mode) begin
        m_refr <= 1;
        m_cnt <= 10;
      end else begin
        mem_ack <= 1;
        m_cnt <= acc_len;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic see(input bit d, input bit p);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s on port %0d", d ? "done" : "gnt", p);
    end else begin
      e = q.pop_front();
      chk(d ? "done port" : "gnt port", {d, p, p0_gnt & p1_gnt, p0_done & p1_done}, {e.done, e.port, 2'b00});
      if (d) begin
        chk("done rd_data", rd_data, e.data);
        chk("done err", err, e.err);
      end else begin
        chk("gnt mem_addr", mem_addr, e.addr);
        chk("gnt mem_write", mem_write, e.wr);
        chk("gnt mem_wdata", mem_wdata, e.data);
      end
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (p0_done | p1_done) see(1'b1, p1_done);
    if (p0_gnt | p1_gnt) see(1'b0, p1_gnt);
  end

  task automatic reset_check(input string n);
    chk({n, " ctrl"}, {p0_gnt, p1_gnt, p0_done, p1_done, mem_ena, mem_write, err}, 0);
    chk({n, " mem_addr"}, mem_addr, 0);
    chk({n, " mem_wdata"}, mem_wdata, 0);
    chk({n, " rd_data"}, rd_data, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_access(input bit p, input bit wr, input logic [23:0] a, input logic [7:0] wd,
                           input logic [7:0] rdv, input bit to);
    bit got = 0, fin = 0, ackd = 0;
    q.push_back('{1'b0, p, a, wr, wd, 1'b0});
    q.push_back('{1'b1, p, 24'h0, 1'b0, to ? 8'hFF : rdv, to});
    ena_cyc = 0; viol = 0; stable_bad = 0; other_bad = 0; ena_bad = 0;
    mem_rd_data = rdv;
    if (p) begin
      p1_write = wr; p1_addr = a; p1_wdata = wd; p1_req = 1;
    end else begin
      p0_write = wr; p0_addr = a; p0_wdata = wd; p0_req = 1;
    end
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (p ? p1_gnt : p0_gnt) begin
        got = 1;
        if (p) p1_req = 0; else p0_req = 0;
      end
      if (mem_ena) ena_cyc++;
      if (!got && mem_ena) viol++;
      if (got && (mem_addr !== a || mem_wdata !== wd || mem_write !== wr)) stable_bad++;
      if (p ? (p0_gnt | p0_done) : (p1_gnt | p1_done)) other_bad++;
      if (ackd && mem_ena) ena_bad++;
      ackd |= mem_ack & mem_busy;
      fin = p ? p1_done : p0_done;
    end
    chk("access completes", fin, 1);
    drain();
  endtask

  initial begin
    int n;
    bit w;
    repeat (3) @(negedge clk);
    rst = 0;
    reset_check("reset");

    do_access(0, 0, 24'h123456, 8'h00, 8'hA5, 0);
    chk("read ena off after ack", ena_bad, 0);
    chk("read cmd stable", stable_bad, 0);
    chk("read p1 quiet", other_bad, 0);
    chk("read no early ena", viol, 0);

    do_access(1, 1, 24'hABCDEF, 8'h3C, 8'h11, 0);
    chk("write cmd stable", stable_bad, 0);
    chk("write p0 quiet", other_bad, 0);
    chk("write ena off after ack", ena_bad, 0);

    refresh_mode = 1;
    do_access(0, 0, 24'h000777, 8'h00, 8'hC3, 0);
    refresh_mode = 0;
    chk("refresh ena held", ena_cyc >= 11, 1);
    chk("refresh err clear", err, 0);
    chk("refresh ena off after ack", ena_bad, 0);

    do_reset();
    mem_rd_data = 8'h5A;
    p0_addr = 24'h111111; p1_addr = 24'h222222;
    p0_write = 0; p1_write = 0; p0_wdata = 0; p1_wdata = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef DRAM_ARB_RR_EN
      w = k % 2 == 1;
`else
      w = 0;
`endif
      q.push_back('{1'b0, w, w ? 24'h222222 : 24'h111111, 1'b0, 8'h00, 1'b0});
      q.push_back('{1'b1, w, 24'h0, 1'b0, 8'h5A, 1'b0});
    end
    p0_req = 1; p1_req = 1; n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      n += int'(p0_gnt) + int'(p1_gnt);
    end
    p0_req = 0; p1_req = 0;
    chk("contention grants", n, 4);
    drain();

    do_reset();
    acc_len = 12;
    mem_rd_data = 8'h99;
    q.push_back('{1'b0, 1'b0, 24'h0F0F0F, 1'b0, 8'h00, 1'b0});
    p0_addr = 24'h0F0F0F; p0_req = 1; n = 0;
    for (int i = 0; i < 100 && !p0_gnt; i++) @(negedge clk);
    chk("pre-reset gnt", p0_gnt, 1);
    p0_req = 0;
    for (int i = 0; i < 100 && mem_ena; i++) @(negedge clk);
    chk("pre-reset in wait", mem_ena, 0);
    @(negedge clk);
    rst = 1;
    p1_req = 1; p1_addr = 24'h000ABC; p1_write = 1; p1_wdata = 8'h42;
    @(negedge clk);
    rst = 0;
    reset_check("mid-access reset");
    chk("controller still busy", mem_busy, 1);
    acc_len = 3;
    do_access(1, 1, 24'h000ABC, 8'h42, 8'h66, 0);
    chk("no ena while draining", viol, 0);
    chk("post-reset p0 quiet", other_bad, 0);

    noack = 1;
    do_access(0, 0, 24'h000100, 8'h00, 8'h77, 1);
    noack = 0;
    chk("timeout err", err, 1);
    chk("timeout length", ena_cyc >= 20 && ena_cyc <= 22, 1);
    chk("timeout ena off", mem_ena, 0);
    repeat (3) @(negedge clk);
    chk("err sticky", err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter and sequencer in front of the TMS4464 SIMM DRAM controller. It accepts byte read/write requests from two independent clients, picks one, and drives the controller's `addr`/`write`/`ena` handshake. It holds the address and write data stable for the whole DRAM cycle and returns completion and read data to the winning client. It sits between the test/CPU logic and the DRAM controller; only one DRAM access is ever outstanding.

## Interface
- `TIMEOUT`, 255: cycles allowed from entering ISSUE to controller completion before abort.
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `p0_req`, `p1_req` in 1: request level; client holds it with its command until `gnt`.
- `p0_write`, `p1_write` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 24: byte address; [23:12] is the row, [11:0] the column.
- `p0_wdata`, `p1_wdata` in 8: write data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle pulse; the command has been latched and the client may change or drop it.
- `p0_done`, `p1_done` out 1: one-cycle pulse; the access is complete.
- `rd_data` out 8: read result, valid while the relevant `done` is high.
- `err` out 1: sticky timeout flag, cleared only by `rst`.
- `mem_addr` out 24: to controller `addr`.
- `mem_write` out 1: to controller `write`.
- `mem_ena` out 1: to controller `ena`.
- `mem_wdata` out 8: drives the DQ tristate driver during writes.
- `mem_rd_data` in 8: from controller `rd_data`.
- `mem_busy` in 1: from controller `busy`.
- `mem_ack` in 1: from controller `ack`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Grant only if a request is pending and `mem_busy`=0.
  - On grant, latch the winner's addr/write/wdata into `mem_*`, pulse that port's `gnt`, set `mem_ena`=1, load the timeout counter, and go to ISSUE.
- ISSUE:
  - Hold `mem_ena`=1 until `mem_ack`=1 && `mem_busy`=1, then set `mem_ena`=0 and go to WAIT_DONE.
  - `mem_ack` without `mem_busy` is stale and is ignored.
  - `mem_busy`=1 with `mem_ack`=0 means a refresh is in progress; keep waiting.
- WAIT_DONE:
  - On `mem_busy`=0, capture `mem_rd_data` into `rd_data` (for reads and writes), pulse the owner's `done`, and go to IDLE.
- `mem_addr`, `mem_write` and `mem_wdata` change only on a grant. They stay stable from grant through the end of WAIT_DONE.
- Selection:
  - Round-robin pointer `last` (reset value 1): when both ports request, the port other than `last` wins.
  - `last` updates on every grant.
- Timeout:
  - The counter decrements each cycle in ISSUE and WAIT_DONE.
  - At 0: set `err`=1, `mem_ena`=0, pulse the owner's `done` with `rd_data`=8'hFF, and go to IDLE.
  - Counter width is $clog2(TIMEOUT+1).
- Reset values: state IDLE, every `gnt`/`done`=0, `mem_ena`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `rd_data`=0, `err`=0, `last`=1.
- Reset mid-access:
  - The controller has no reset, so it may stay busy.
  - The IDLE rule (`mem_busy`=0) prevents a new issue until that access drains.
  - The result of the access in flight at reset is discarded; no `done` is produced for it.

## Timing
- Grant at edge e. `mem_ena` is high from e.
- With the controller idle: it samples `ena` at e+1, and `ack`/`busy` rise after e+1. The arbiter enters WAIT_DONE at e+2, and `mem_ena` is low after e+2.
- `done`/`rd_data` become valid one cycle after the first cycle in which `mem_busy`=0 is observed in WAIT_DONE.
- Back-to-back: a new grant can occur on the edge after `done` is registered, because the IDLE `mem_busy` check already passes.
- A refresh collision extends ISSUE by the refresh length; `mem_ena` stays asserted throughout.
- `gnt` and `done` for the same access are never in the same cycle.

## Configuration
- `DRAM_ARB_RR_EN` defined: round-robin selection as above.
- `DRAM_ARB_RR_EN` undefined:
  - Fixed priority, port 0 always wins a simultaneous request.
  - `last` is not implemented.
  - Port 1 can starve while port 0 holds `req`.

## Test plan
- Single read: `p0_req`, addr 0x123456; the model returns 0xA5 → `mem_addr`=0x123456, `mem_write`=0, exactly one `p0_gnt` and one `p0_done`, `rd_data`=0xA5, `mem_ena` deasserted after `ack`.
- Single write: `p1_req`, addr 0xABCDEF, wdata 0x3C → `mem_write`=1, `mem_wdata`=0x3C stable until `busy` falls, one `p1_done`, `p0` outputs quiet.
- Contention, both ports requesting continuously for 4 accesses:
  - With the macro defined: grant order p0, p1, p0, p1.
  - With the macro undefined: p0, p0, p0, p0.
- Refresh collision: the model holds `busy`=1, `ack`=0 for 10 cycles when `ena` rises → `mem_ena` held 10+ cycles, single access, `err`=0.
- Timeout: the model never acks, `TIMEOUT`=20 → `err`=1 after 20 cycles in ISSUE, `p0_done` pulse, `rd_data`=0xFF, state IDLE.
- Reset in WAIT_DONE with the model still busy for 8 cycles → all outputs at reset values, `mem_ena` stays 0 until `mem_busy` falls, then a pending `p1_req` is granted normally.
